ref_block_loader: RTL and testbench
===================================

REF_BLOCK_LOADER -- requirements
Module: ref_block_loader

Interface
REQ-001 The block SHALL use one clock, clk; reset is rst, synchronous and active-low; all state changes occur on the rising edge of clk.
REQ-002 Port list SHALL be exactly:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
s_valid  input  1  upstream pixel valid
s_ready  output  1  loader can accept a pixel
s_pixel  input  8  integer reference pixel, raster order
blk_valid  output  1  complete 15x15 block readable
blk_done  input  1  interpolator finished with current block (1-cycle pulse)
next_row  input  8  row index requested by interpolator
in_row  output  120  requested row; pixel j in bits [8j+7:8j]
fill_row  output  4  current write row (0..14)
fill_col  output  4  current write column (0..14)

Function
REQ-003 Beat SHALL be accepted iff s_valid && s_ready on a rising edge; pixel stored at [fill_row][fill_col] of write bank.
REQ-004 After each accepted beat fill_col SHALL increment; at 14 it wraps to 0 and fill_row increments.
REQ-005 Accepting beat at (14,14) SHALL mark write bank full and reset pointers to (0,0) in the same edge.
REQ-006 s_ready SHALL be 1 exactly when write bank is not full and rst is high.
REQ-007 blk_valid SHALL equal the full flag of the read bank; rises the cycle after the 225th beat is accepted (1-cycle latency).
REQ-008 in_row SHALL be combinational from next_row (zero latency): row next_row of read bank when blk_valid=1 and next_row<=14; otherwise 120'h0.
REQ-009 blk_done while blk_valid=1 SHALL clear read bank full flag; blk_done while blk_valid=0 SHALL be ignored.
REQ-010 Last-beat accept and blk_done in the same cycle SHALL both take effect independently.
REQ-011 s_pixel is unsigned 8-bit, stored unmodified; no arithmetic performed.

Reset
REQ-012 While rst=0: s_ready=0, blk_valid=0, in_row=0, fill_row=0, fill_col=0, all full flags cleared, bank selects=0.
REQ-013 Reset mid-fill SHALL discard partial block; first beat after release writes (0,0). Pixel storage is not reset.

Configuration
REQ-014 Macro REF_LOADER_PINGPONG_EN defined: two banks; write bank toggles on REQ-005, read bank toggles on accepted blk_done; filling of bank B proceeds while bank A is read.
REQ-015 Macro undefined: single bank used for both read and write; s_ready=0 from full until cycle after accepted blk_done; s_valid held meanwhile SHALL NOT advance pointers.

Structure
REQ-016 Package ref_loader_pkg SHALL hold BLK_DIM=15, PIX_W=8, ROW_W=120, and 4-bit pointer typedef.
REQ-017 Sub-module ref_bank SHALL implement one 15x120 storage bank with byte write port and row read port; instantiated once or twice per REQ-014/015.

Verification
REQ-018 Reset, stream 225 beats pixel=(15r+c) mod 256 -> blk_valid=1 next cycle; next_row=0 gives in_row=0x0e0d0c...0100; next_row=14 gives bytes 0xd2..0xe0 (0xe0 in MSB).
REQ-019 Full block loaded, next_row=15 and 0xFF -> in_row=0.
REQ-020 PINGPONG_EN: stream second block (pixel+1) while blk_valid held -> s_ready stays 1 for 225 beats then 0; in_row still shows block 1; pulse blk_done -> next cycle in_row row0 = 0x0f0e...01, s_ready=1.
REQ-021 Macro undefined: after 225 beats s_ready=0, s_valid held 10 cycles -> fill_row/fill_col stay 0; blk_done -> blk_valid=0, s_ready=1 next cycle.
REQ-022 Assert rst=0 after 100 beats -> all outputs 0; after release 225 fresh beats required for blk_valid; blk_done pulse with blk_valid=0 -> no state change.
REQ-023 Random s_valid gaps (50% duty) -> stored block identical to gap-free load.

Source files
------------

// File: rtl/ref_loader_pkg.sv
// Purpose: shared constants and types for the reference block loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ref_loader_pkg;

  localparam int BLK_DIM = 15;
  localparam int PIX_W   = 8;
  localparam int ROW_W   = 120;

  // Row/column pointer into a 15x15 block
  typedef logic [3:0] ptr_t;

  localparam ptr_t PTR_LAST = 4'(BLK_DIM - 1);

endpackage

// File: rtl/ref_block_loader_bank.sv
// Purpose: one 15x120 reference storage bank, byte write port and row read port.
// Latency: write lands on the clock edge; row read is combinational.
// Backpressure: none; the caller decides when to write.
module ref_bank
  import ref_loader_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  ptr_t             wr_row,
  input  ptr_t             wr_col,
  input  logic [PIX_W-1:0] wr_pix,
  input  ptr_t             rd_row,
  output logic [ROW_W-1:0] rd_dat
);

  // Pixel storage is deliberately not reset; validity is tracked by the loader.
  logic [ROW_W-1:0] mem_q [BLK_DIM];

  // Byte write into the addressed row
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_row][wr_col*PIX_W +: PIX_W] <= wr_pix;
    end
  end

  // Row read; pointer 15 has no storage behind it and reads as zero
  always_comb begin
    rd_dat = '0;
    if (rd_row <= PTR_LAST) begin
      rd_dat = mem_q[rd_row];
    end
  end

endmodule

// File: rtl/ref_block_loader.sv
// Purpose: fills 15x15 reference blocks in raster order; optional ping-pong via REF_LOADER_PINGPONG_EN.
// Latency: blk_valid rises one cycle after the 225th beat; in_row is combinational from next_row.
// Backpressure: s_ready drops while the write bank is full, returns the cycle after blk_done frees it.
module ref_block_loader
  import ref_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  output logic             blk_valid,
  input  logic             blk_done,
  input  logic [7:0]       next_row,
  output logic [ROW_W-1:0] in_row,
  output logic [3:0]       fill_row,
  output logic [3:0]       fill_col
);

`ifdef REF_LOADER_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  ptr_t       fill_row_q, fill_row_d;
  ptr_t       fill_col_q, fill_col_d;
  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;

  logic             accept;
  logic             last_beat;
  logic             done_acc;
  logic [ROW_W-1:0] bank_row [2];

  assign s_ready   = rst & ~full_q[wr_sel_q];
  assign blk_valid = rst & full_q[rd_sel_q];
  assign accept    = s_valid & s_ready;
  assign done_acc  = blk_done & blk_valid;
  assign last_beat = (fill_row_q == PTR_LAST) && (fill_col_q == PTR_LAST);
  assign fill_row  = rst ? fill_row_q : 4'd0;
  assign fill_col  = rst ? fill_col_q : 4'd0;

`ifdef REF_LOADER_PINGPONG_EN
  ref_bank u_bank0 (
    .clk    (clk),
    .wr_en  (accept && !wr_sel_q),
    .wr_row (fill_row_q),
    .wr_col (fill_col_q),
    .wr_pix (s_pixel),
    .rd_row (next_row[3:0]),
    .rd_dat (bank_row[0])
  );
  ref_bank u_bank1 (
    .clk    (clk),
    .wr_en  (accept && wr_sel_q),
    .wr_row (fill_row_q),
    .wr_col (fill_col_q),
    .wr_pix (s_pixel),
    .rd_row (next_row[3:0]),
    .rd_dat (bank_row[1])
  );
`else
  ref_bank u_bank0 (
    .clk    (clk),
    .wr_en  (accept),
    .wr_row (fill_row_q),
    .wr_col (fill_col_q),
    .wr_pix (s_pixel),
    .rd_row (next_row[3:0]),
    .rd_dat (bank_row[0])
  );
  assign bank_row[1] = '0;
`endif

  // Read mux: only a full read bank and an in-range row produce data
  always_comb begin
    in_row = '0;
    if (blk_valid && (next_row <= 8'(BLK_DIM - 1))) begin
      in_row = bank_row[rd_sel_q];
    end
  end

  // Next-state: raster pointers, full flags and bank selects
  always_comb begin
    fill_row_d = fill_row_q;
    fill_col_d = fill_col_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    if (accept) begin
      if (fill_col_q == PTR_LAST) begin
        fill_col_d = 4'd0;
        fill_row_d = (fill_row_q == PTR_LAST) ? 4'd0 : fill_row_q + 4'd1;
      end else begin
        fill_col_d = fill_col_q + 4'd1;
      end
      if (last_beat) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = wr_sel_q ^ PINGPONG;
      end
    end
    // Release is independent of the fill: with two banks it never targets the bank just completed
    if (done_acc) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = rd_sel_q ^ PINGPONG;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_row_q <= 4'd0;
      fill_col_q <= 4'd0;
      full_q     <= 2'b00;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      fill_row_q <= fill_row_d;
      fill_col_q <= fill_col_d;
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

endmodule

// File: tb/tb_ref_block_loader.sv
// Purpose: self-checking bench for ref_block_loader (either REF_LOADER_PINGPONG_EN build).
// Latency: model tracks whole blocks as a queue; outputs compared every falling edge.
// Backpressure: model readiness is "fewer full blocks than banks".
module tb_ref_block_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_pixel = 8'd0;
  logic         blk_valid;
  logic         blk_done = 1'b0;
  logic [7:0]   next_row = 8'd0;
  logic [119:0] in_row;
  logic [3:0]   fill_row;
  logic [3:0]   fill_col;

`ifdef REF_LOADER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  localparam logic [119:0] R0   = 120'h0e0d0c0b0a09080706050403020100;
  localparam logic [119:0] R14  = 120'he0dfdedddcdbdad9d8d7d6d5d4d3d2;
  localparam logic [119:0] R0B2 = 120'h0f0e0d0c0b0a090807060504030201;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: completed blocks waiting to be consumed, plus the block being filled
  logic [1799:0] blkq[$];
  logic [1799:0] part;
  int            pcnt = 0;

  ref_block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_pixel   (s_pixel),
    .blk_valid (blk_valid),
    .blk_done  (blk_done),
    .next_row  (next_row),
    .in_row    (in_row),
    .fill_row  (fill_row),
    .fill_col  (fill_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each rising edge
  always @(posedge clk) begin : model
    bit            acc;
    bit            dn;
    logic [1799:0] tmp;
    if (!rst) begin
      blkq.delete();
      pcnt = 0;
    end else begin
      acc = s_valid && (blkq.size() < CAP);
      dn  = blk_done && (blkq.size() > 0);
      if (dn) tmp = blkq.pop_front();
      if (acc) begin
        part[pcnt*8 +: 8] = s_pixel;
        pcnt++;
        if (pcnt == 225) begin
          blkq.push_back(part);
          pcnt = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [119:0]  exp_row;
    logic [1799:0] f;
    bit            mv;
    int            r;
    if (cmp_en) begin
      mv = rst && (blkq.size() > 0);
      r  = int'(next_row);
      exp_row = '0;
      if (mv && r <= 14) begin
        f = blkq[0];
        exp_row = f[r*120 +: 120];
      end
      chk("cyc_s_ready", s_ready, rst && (blkq.size() < CAP));
      chk("cyc_blk_valid", blk_valid, mv);
      chk("cyc_in_row", in_row, exp_row);
      chk("cyc_fill_row", fill_row, rst ? 4'(pcnt / 15) : 4'd0);
      chk("cyc_fill_col", fill_col, rst ? 4'(pcnt % 15) : 4'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted, bounded
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_pixel = v;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready stuck at %b, required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic load(input int base, input bit gaps);
    for (int i = 0; i < 225; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        s_valid = 1'b0;
        tick();
      end
      send(8'(i + base));
    end
  endtask

  task automatic pulse_done();
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_in_row", in_row, 0);
    chk("rst_fill_row", fill_row, 0);
    chk("rst_fill_col", fill_col, 0);
    rst = 1'b1;
    tick();

    // First block, gap-free
    load(0, 1'b0);
    chk("blk1_valid", blk_valid, 1);
    next_row = 8'd0;   #1; chk("blk1_row0", in_row, R0);
    next_row = 8'd14;  #1; chk("blk1_row14", in_row, R14);
    next_row = 8'd15;  #1; chk("row15_zero", in_row, 0);
    next_row = 8'hff;  #1; chk("rowff_zero", in_row, 0);
    next_row = 8'd0;
    tick();

`ifdef REF_LOADER_PINGPONG_EN
    // Second block fills while the first is held for reading
    for (int i = 0; i < 225; i++) begin
      chk("pp_ready_during_fill", s_ready, 1);
      send(8'(i + 1));
    end
    chk("pp_ready_after_fill", s_ready, 0);
    chk("pp_still_blk1", in_row, R0);
    pulse_done();
    chk("pp_blk2_row0", in_row, R0B2);
    chk("pp_ready_after_done", s_ready, 1);
    pulse_done();
    chk("pp_empty", blk_valid, 0);
`else
    // Held valid against a full bank must not move the pointers
    s_valid = 1'b1;
    s_pixel = 8'haa;
    repeat (10) tick();
    chk("hold_fill_row", fill_row, 0);
    chk("hold_fill_col", fill_col, 0);
    chk("hold_s_ready", s_ready, 0);
    s_valid = 1'b0;
    pulse_done();
    chk("done_blk_valid", blk_valid, 0);
    chk("done_s_ready", s_ready, 1);
`endif

    // Reset mid-fill after 100 beats
    for (int i = 0; i < 100; i++) send(8'(i + 7));
    chk("mid_fill_row", fill_row, 6);
    chk("mid_fill_col", fill_col, 10);
    rst = 1'b0;
    #1;
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_fill_row", fill_row, 0);
    chk("mrst_fill_col", fill_col, 0);
    chk("mrst_blk_valid", blk_valid, 0);
    tick();
    tick();
    rst = 1'b1;
    pulse_done();
    chk("ign_done_valid", blk_valid, 0);
    chk("ign_done_ready", s_ready, 1);
    chk("ign_done_col", fill_col, 0);
    for (int i = 0; i < 224; i++) send(8'(i));
    chk("beat224_not_valid", blk_valid, 0);
    send(8'd224);
    chk("beat225_valid", blk_valid, 1);
    chk("fresh_row0", in_row, R0);
    pulse_done();

    // Random valid gaps must yield the same block
    load(0, 1'b1);
    next_row = 8'd0;  #1; chk("gap_row0", in_row, R0);
    next_row = 8'd14; #1; chk("gap_row14", in_row, R14);
    next_row = 8'd0;
    tick();
    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
